// File: rtl/msrv32_wb_reg_file.sv
// -----------------------------------------------------------------------------
// msrv32_wb_reg_file
//   Integer register file (x1..x31) written from the writeback mux stage. It
//   includes a pending-write scoreboard that generates RAW/WAW hazard stalls
//   for the issue stage.
//
// Parameters
//   BYPASS_EN : 1 forwards the writeback data to a read port in the same cycle
//   XLEN      : register / data width
//
// Ports
//   ms_riscv32_mp_clk_in   : clock; all state updates on the rising edge
//   ms_riscv32_mp_rst_in   : synchronous active-high reset
//   rs1_addr_in            : read port 1 register index
//   rs2_addr_in            : read port 2 register index
//   issue_valid_in         : an instruction writing issue_rd_in is issuing
//   issue_rd_in            : destination index of the issuing instruction
//   wb_valid_in            : writeback strobe
//   wb_rd_addr_in          : writeback destination index
//   wb_data_in             : writeback data
//   flush_in               : discard all outstanding producers
//   rs1_data_out           : combinational read data, port 1
//   rs2_data_out           : combinational read data, port 2
//   stall_out              : hazard stall request to the issue stage
//   pending_cnt_out        : registered count of pending registers
// -----------------------------------------------------------------------------
module msrv32_wb_reg_file #(
  parameter int BYPASS_EN = 1,
  parameter int XLEN      = 32
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  input  logic            issue_valid_in,
  input  logic [4:0]      issue_rd_in,
  input  logic            wb_valid_in,
  input  logic [4:0]      wb_rd_addr_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            flush_in,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic            stall_out,
  output logic [4:0]      pending_cnt_out
);

  // Number of set bits; bit 0 of the scoreboard is always 0, so the result fits 0..31.
  function automatic logic [4:0] popcount31(input logic [31:0] vec);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 1; i < 32; i++) begin
      cnt = cnt + {4'd0, vec[i]};
    end
    return cnt;
  endfunction

  logic [XLEN-1:0] r_regs [1:31];
  logic [31:0]     r_pending;      // bit 0 is held at 0 so x0 is never pending
  logic [4:0]      r_pending_cnt;

  logic            w_byp_en;
  logic            w_wb_live;      // writeback that targets a real register
  logic            w_rs1_wb_hit;
  logic            w_rs2_wb_hit;
  logic            w_rs1_block;
  logic            w_rs2_block;
  logic            w_waw_block;
  logic            w_stall;
  logic            w_issue_accept;
  logic [31:0]     w_clr_mask;
  logic [31:0]     w_set_mask;
  logic [31:0]     w_pending_nxt;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  assign w_byp_en  = (BYPASS_EN != 0);
  assign w_wb_live = wb_valid_in && (wb_rd_addr_in != 5'd0);

  // Read ports: x0 is hard zero, bypass from writeback, otherwise the array.
  always_comb begin
    w_rs1_wb_hit = w_wb_live && (wb_rd_addr_in == rs1_addr_in);
    w_rs2_wb_hit = w_wb_live && (wb_rd_addr_in == rs2_addr_in);
    w_rs1_data   = '0;
    w_rs2_data   = '0;
    if (rs1_addr_in == 5'd0) begin
      w_rs1_data = '0;
    end else if (w_byp_en && w_rs1_wb_hit) begin
      w_rs1_data = wb_data_in;
    end else begin
      w_rs1_data = r_regs[rs1_addr_in];
    end
    if (rs2_addr_in == 5'd0) begin
      w_rs2_data = '0;
    end else if (w_byp_en && w_rs2_wb_hit) begin
      w_rs2_data = wb_data_in;
    end else begin
      w_rs2_data = r_regs[rs2_addr_in];
    end
  end

  // Hazard detection. A pending source is resolved only by a bypassed
  // writeback. A WAW on the destination is resolved by any same-cycle writeback
  // because the scoreboard bit is re-set by the new issue anyway.
  always_comb begin
    w_rs1_block    = r_pending[rs1_addr_in] && !(w_byp_en && w_rs1_wb_hit);
    w_rs2_block    = r_pending[rs2_addr_in] && !(w_byp_en && w_rs2_wb_hit);
    w_waw_block    = issue_valid_in && r_pending[issue_rd_in] &&
                     !(wb_valid_in && (wb_rd_addr_in == issue_rd_in));
    w_stall        = w_rs1_block || w_rs2_block || w_waw_block;
    w_issue_accept = issue_valid_in && !w_stall && !flush_in &&
                     (issue_rd_in != 5'd0);
  end

  // Next scoreboard state: flush wins; otherwise clear on writeback, then set on issue.
  always_comb begin
    w_clr_mask    = 32'd0;
    w_set_mask    = 32'd0;
    w_pending_nxt = r_pending;
    if (wb_valid_in) begin
      w_clr_mask = 32'd1 << wb_rd_addr_in;
    end else begin
      w_clr_mask = 32'd0;
    end
    if (w_issue_accept) begin
      w_set_mask = 32'd1 << issue_rd_in;
    end else begin
      w_set_mask = 32'd0;
    end
    if (flush_in) begin
      w_pending_nxt = 32'd0;
    end else begin
      w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & 32'hFFFF_FFFE;
    end
  end

  // Register array update.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[wb_rd_addr_in] <= wb_data_in;
    end
  end

  // Scoreboard and its registered population count.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_pending     <= 32'd0;
      r_pending_cnt <= 5'd0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_pending_cnt <= popcount31(w_pending_nxt);
    end
  end

  assign rs1_data_out    = w_rs1_data;
  assign rs2_data_out    = w_rs2_data;
  assign stall_out       = w_stall;
  assign pending_cnt_out = r_pending_cnt;

endmodule

// File: tb/tb_msrv32_wb_reg_file.sv
module tb_msrv32_wb_reg_file;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      rs1, rs2, ird, wbrd;
  logic            iv, wbv, fl;
  logic [XLEN-1:0] wbdata;

  logic [XLEN-1:0] rs1_b1, rs2_b1, rs1_b0, rs2_b0;
  logic            stall_b1, stall_b0;
  logic [4:0]      cnt_b1, cnt_b0;

  msrv32_wb_reg_file #(.BYPASS_EN(1), .XLEN(XLEN)) u_dut_b1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .rs1_addr_in(rs1), .rs2_addr_in(rs2),
    .issue_valid_in(iv), .issue_rd_in(ird),
    .wb_valid_in(wbv), .wb_rd_addr_in(wbrd), .wb_data_in(wbdata),
    .flush_in(fl),
    .rs1_data_out(rs1_b1), .rs2_data_out(rs2_b1),
    .stall_out(stall_b1), .pending_cnt_out(cnt_b1)
  );

  msrv32_wb_reg_file #(.BYPASS_EN(0), .XLEN(XLEN)) u_dut_b0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
    .rs1_addr_in(rs1), .rs2_addr_in(rs2),
    .issue_valid_in(iv), .issue_rd_in(ird),
    .wb_valid_in(wbv), .wb_rd_addr_in(wbrd), .wb_data_in(wbdata),
    .flush_in(fl),
    .rs1_data_out(rs1_b0), .rs2_data_out(rs2_b0),
    .stall_out(stall_b0), .pending_cnt_out(cnt_b0)
  );

  // Expected observation for one cycle; index 1 = bypass instance, 0 = no bypass.
  typedef struct {
    logic [1:0][31:0] rd1;
    logic [1:0][31:0] rd2;
    logic [1:0]       stall;
    logic [1:0][4:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: architectural registers and a set of pending indices.
  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];
  int          m_cnt  [2];
  bit          m_acc  [2];
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict outputs, wait to the sampling edge.
  task automatic apply(input bit r, input bit iv_i, input logic [4:0] ird_i,
                       input bit wbv_i, input logic [4:0] wbrd_i, input logic [31:0] d,
                       input bit fl_i, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    bit   h1, h2, waw, st;
    rst = r; iv = iv_i; ird = ird_i; wbv = wbv_i; wbrd = wbrd_i;
    wbdata = d; fl = fl_i; rs1 = a1; rs2 = a2;
    for (int b = 0; b < 2; b++) begin
      e.rd1[b] = (a1 == 5'd0) ? 32'd0 :
                 ((b == 1) && wbv_i && wbrd_i == a1) ? d : m_regs[b][a1];
      e.rd2[b] = (a2 == 5'd0) ? 32'd0 :
                 ((b == 1) && wbv_i && wbrd_i == a2) ? d : m_regs[b][a2];
      h1  = m_pend[b][a1] && !((b == 1) && wbv_i && wbrd_i == a1);
      h2  = m_pend[b][a2] && !((b == 1) && wbv_i && wbrd_i == a2);
      waw = iv_i && m_pend[b][ird_i] && !(wbv_i && wbrd_i == ird_i);
      st  = h1 || h2 || waw;
      e.stall[b] = st;
      e.cnt[b]   = m_cnt[b][4:0];
      m_acc[b]   = iv_i && !st && !fl_i && (ird_i != 5'd0);
    end
    if (m_valid) q.push_back(e);
    @(negedge clk);
  endtask

  // Clock edge: advance the model with the inputs that were applied.
  task automatic advance();
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_regs[b][i] = 32'd0;
          m_pend[b][i] = 1'b0;
        end
      end else begin
        if (wbv && wbrd != 5'd0) m_regs[b][wbrd] = wbdata;
        if (fl) begin
          for (int i = 0; i < 32; i++) m_pend[b][i] = 1'b0;
        end else begin
          if (wbv) m_pend[b][wbrd] = 1'b0;
          if (m_acc[b]) m_pend[b][ird] = 1'b1;
        end
      end
      m_cnt[b] = 0;
      for (int i = 1; i < 32; i++) m_cnt[b] += int'(m_pend[b][i]);
    end
    if (rst) m_valid = 1'b1;
    #1;
  endtask

  task automatic step(input bit r, input bit iv_i, input logic [4:0] ird_i,
                      input bit wbv_i, input logic [4:0] wbrd_i, input logic [31:0] d,
                      input bit fl_i, input logic [4:0] a1, input logic [4:0] a2);
    apply(r, iv_i, ird_i, wbv_i, wbrd_i, d, fl_i, a1, a2);
    advance();
  endtask

  // Monitor: outputs are presented every cycle; pop and compare at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_rs1_byp",    rs1_b1,   e.rd1[1]);
        chk("sb_rs2_byp",    rs2_b1,   e.rd2[1]);
        chk("sb_stall_byp",  {31'd0, stall_b1}, {31'd0, e.stall[1]});
        chk("sb_cnt_byp",    {27'd0, cnt_b1},   {27'd0, e.cnt[1]});
        chk("sb_rs1_nobyp",  rs1_b0,   e.rd1[0]);
        chk("sb_rs2_nobyp",  rs2_b0,   e.rd2[0]);
        chk("sb_stall_nobyp", {31'd0, stall_b0}, {31'd0, e.stall[0]});
        chk("sb_cnt_nobyp",  {27'd0, cnt_b0},   {27'd0, e.cnt[0]});
      end
    end
  end

  initial begin
    rst = 1'b1; iv = 1'b0; ird = 5'd0; wbv = 1'b0; wbrd = 5'd0;
    wbdata = 32'd0; fl = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    step(1, 0, 0, 0, 0, 32'd0, 0, 0, 0);

    // Write x5, read it back next cycle.
    apply(0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    chk("post_reset_stall", {31'd0, stall_b1}, 32'd0);
    chk("post_reset_rs1",   rs1_b1, 32'd0);
    chk("post_reset_cnt",   {27'd0, cnt_b1}, 32'd0);
    advance();
    apply(0, 0, 0, 0, 0, 32'd0, 0, 5, 0);
    chk("x5_read",    rs1_b1, 32'hDEAD_BEEF);
    chk("x0_read",    rs2_b1, 32'd0);
    advance();

    // Same-cycle bypass vs. no bypass.
    apply(0, 0, 0, 1, 7, 32'h1234_5678, 0, 0, 7);
    chk("bypass_rs2",   rs2_b1, 32'h1234_5678);
    chk("nobypass_rs2", rs2_b0, 32'd0);
    advance();

    // RAW on x3 resolved by bypassed writeback.
    step(0, 1, 3, 0, 0, 32'd0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 32'd0, 0, 3, 0);
    chk("raw_stall", {31'd0, stall_b1}, 32'd1);
    chk("raw_cnt",   {27'd0, cnt_b1},   32'd1);
    advance();
    apply(0, 0, 0, 1, 3, 32'h0000_00AA, 0, 3, 0);
    chk("raw_bypass_nostall", {31'd0, stall_b1}, 32'd0);
    chk("raw_nobypass_stall", {31'd0, stall_b0}, 32'd1);
    advance();
    apply(0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
    chk("raw_cnt_after", {27'd0, cnt_b1}, 32'd0);
    advance();

    // Issue and writeback to the same pending index keeps it pending.
    step(0, 1, 4, 0, 0, 32'd0, 0, 0, 0);
    apply(0, 1, 4, 1, 4, 32'h55, 0, 0, 0);
    chk("waw_clr_nostall", {31'd0, stall_b1}, 32'd0);
    advance();
    apply(0, 1, 4, 0, 0, 32'd0, 0, 0, 0);
    chk("waw_cnt",   {27'd0, cnt_b1},   32'd1);
    chk("waw_stall", {31'd0, stall_b1}, 32'd1);
    advance();
    step(0, 0, 0, 1, 4, 32'h66, 0, 0, 0);

    // Flush beats a concurrent issue.
    step(0, 1, 1, 0, 0, 32'd0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 32'd0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 32'd0, 0, 0, 0);
    apply(0, 1, 9, 0, 0, 32'd0, 1, 0, 0);
    chk("pre_flush_cnt", {27'd0, cnt_b1}, 32'd3);
    advance();
    apply(0, 0, 0, 0, 0, 32'd0, 0, 9, 0);
    chk("flush_cnt",      {27'd0, cnt_b1},   32'd0);
    chk("flush_x9_stall", {31'd0, stall_b1}, 32'd0);
    advance();

    // x0 writes and issues are ignored; reset beats a concurrent writeback.
    step(0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
    chk("x0_zero", rs1_b1, 32'd0);
    chk("x0_cnt",  {27'd0, cnt_b1}, 32'd0);
    advance();
    step(1, 1, 6, 1, 5, 32'h0000_0012, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 32'd0, 0, 5, 7);
    chk("rst_rs1", rs1_b1, 32'd0);
    chk("rst_rs2", rs2_b1, 32'd0);
    chk("rst_cnt", {27'd0, cnt_b1}, 32'd0);
    advance();

    // Randomized traffic with a narrow index range to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 9)), $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 9)), $urandom,
           ($urandom_range(0, 29) == 0),
           5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_reg_file.md
MSRV32_WB_REG_FILE -- requirements
Module: msrv32_wb_reg_file

Interface
REQ-001 SHALL have parameter BYPASS_EN, default 1, meaning same-cycle writeback-to-read forwarding enabled.
REQ-002 SHALL have parameter XLEN, default 32, meaning register and data width.
REQ-003 SHALL have port ms_riscv32_mp_clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port ms_riscv32_mp_rst_in, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports rs1_addr_in and rs2_addr_in, input, 5 each, read-port source register indices.
REQ-006 SHALL have port issue_valid_in, input, 1, an instruction writing issue_rd_in is issuing this cycle.
REQ-007 SHALL have port issue_rd_in, input, 5, destination index of the issuing instruction.
REQ-008 SHALL have port wb_valid_in, input, 1, writeback strobe from the writeback mux stage.
REQ-009 SHALL have port wb_rd_addr_in, input, 5, writeback destination index.
REQ-010 SHALL have port wb_data_in, input, XLEN, writeback data (writeback mux output).
REQ-011 SHALL have port flush_in, input, 1, pipeline flush that discards all outstanding producers.
REQ-012 SHALL have ports rs1_data_out and rs2_data_out, output, XLEN each, combinational read data.
REQ-013 SHALL have port stall_out, output, 1, hazard stall request to the issue stage.
REQ-014 SHALL have port pending_cnt_out, output, 5, number of registers currently pending, registered.

Function
REQ-015 SHALL hold 31 XLEN-bit registers x1..x31; x0 SHALL read 0, ignore writes, never be pending.
REQ-016 SHALL write wb_data_in into x[wb_rd_addr_in] on the clock edge when wb_valid_in=1 and wb_rd_addr_in!=0; array visible next cycle.
REQ-017 SHALL drive rsN_data_out = wb_data_in when BYPASS_EN=1, wb_valid_in=1, wb_rd_addr_in=rsN_addr_in!=0; otherwise array value (0 for x0).
REQ-018 SHALL keep a 31-bit pending scoreboard: bit set on issue acceptance, cleared on wb_valid_in for that index.
REQ-019 SHALL accept an issue only when issue_valid_in=1, stall_out=0, flush_in=0, issue_rd_in!=0.
REQ-020 SHALL, when one index is simultaneously cleared by writeback and set by accepted issue, leave it set.
REQ-021 SHALL assert stall_out when rs1 or rs2 is pending and not being resolved by a bypassed writeback this cycle (BYPASS_EN=0: pending alone stalls).
REQ-022 SHALL also assert stall_out when issue_valid_in=1 and issue_rd_in is pending and not cleared by wb this cycle (WAW).
REQ-023 SHALL, on flush_in=1, clear every pending bit at the edge; flush beats issue; a concurrent writeback still writes the array.
REQ-024 SHALL update pending_cnt_out each edge to the popcount of the next scoreboard state (range 0..31).
REQ-025 SHALL ignore writeback to an index that is not pending for scoreboard purposes (data still written).

Reset
REQ-026 SHALL, with ms_riscv32_mp_rst_in=1 at an edge, clear all registers to 0, all pending bits, pending_cnt_out to 0; reset overrides writeback, issue and flush.
REQ-027 SHALL give stall_out=0 and rsN_data_out=0 in the cycle after reset, absent concurrent writeback bypass.

Verification
REQ-028 Reset, then wb_valid=1 rd=5 data=0xDEADBEEF, next cycle rs1=5 -> rs1_data_out=0xDEADBEEF; rs2=0 -> 0.
REQ-029 wb_valid=1 rd=7 data=0x12345678 with rs2=7 same cycle -> rs2_data_out=0x12345678 (BYPASS_EN=1); BYPASS_EN=0 -> old value.
REQ-030 Issue rd=3, next cycle rs1=3 -> stall_out=1, pending_cnt_out=1; wb rd=3 that cycle -> stall_out=0 via bypass; count 0 after.
REQ-031 Issue rd=4 and wb rd=4 same cycle with 4 pending -> bit 4 stays set, pending_cnt_out=1; issue rd=4 again -> stall_out=1.
REQ-032 Issue rd=1,2,3 over three cycles, then flush_in=1 with issue rd=9 -> pending_cnt_out=0, rd 9 not pending.
REQ-033 wb rd=0 data=0xFFFFFFFF, issue rd=0 -> x0 reads 0, pending_cnt_out=0; reset mid-run with wb active -> all reads 0 next cycle.
